// File: rtl/ysyx_201979054_clint_pkg.sv
// Shared constants, FSM encoding and byte-strobe merge helper for the CLINT.
package ysyx_201979054_clint_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned ADDR_W = 16;

    localparam logic [ADDR_W-1:0] MSIP_ADDR     = 16'h0000;
    localparam logic [ADDR_W-1:0] MTIMECMP_ADDR = 16'h4000;
    localparam logic [ADDR_W-1:0] MTIME_ADDR    = 16'hBFF8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Replace the byte lanes of old_val selected by strb with lanes of new_val.
    function automatic logic [XLEN-1:0] strb_merge(
        input logic [XLEN-1:0]   old_val,
        input logic [XLEN-1:0]   new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [XLEN-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_201979054_clint_timer.sv
// mtime/mtimecmp storage with prescaled tick, byte-lane writes and a registered
// compare that drives the machine timer interrupt level.
module ysyx_201979054_clint_timer
    import ysyx_201979054_clint_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    mtime_we,
    input  logic                    mtimecmp_we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   mtime,
    output logic [DATA_WIDTH-1:0]   mtimecmp,
    output logic                    timer_int
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]      prescaler;
    logic                  tick;
    logic [DATA_WIDTH-1:0] mtime_adv;
    logic [DATA_WIDTH-1:0] mtime_next;
    logic [DATA_WIDTH-1:0] mtimecmp_next;

    assign tick = (prescaler == PRE_W'(TICK_DIV - 1));

    // A bus write merges over the already-advanced value so unwritten lanes keep counting.
    always_comb begin
        mtime_adv     = tick ? (mtime + DATA_WIDTH'(1)) : mtime;
        mtime_next    = mtime_we ? strb_merge(mtime_adv, wdata, wstrb) : mtime_adv;
        mtimecmp_next = mtimecmp_we ? strb_merge(mtimecmp, wdata, wstrb) : mtimecmp;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            timer_int <= 1'b0;
        end else begin
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            timer_int <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/ysyx_201979054_clint.sv
// Core-local interruptor: single-outstanding bus port, address decode, msip and
// the timer sub-block feeding the CSR file's MTIP/MSIP inputs.
module ysyx_201979054_clint
    import ysyx_201979054_clint_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    i_req_valid,
    input  logic                    i_req_write,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
    output logic                    o_req_ready,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_resp_rdata,
    output logic                    o_resp_err,
    output logic                    o_timer_int_call,
    output logic                    o_software_int_call
);

    localparam logic [ADDR_WIDTH-1:0] MSIP_A  = ADDR_WIDTH'(MSIP_ADDR);
    localparam logic [ADDR_WIDTH-1:0] CMP_A   = ADDR_WIDTH'(MTIMECMP_ADDR);
    localparam logic [ADDR_WIDTH-1:0] MTIME_A = ADDR_WIDTH'(MTIME_ADDR);

    state_e                state;
    state_e                state_next;

    logic                  sel_msip;
    logic                  sel_cmp;
    logic                  sel_mtime;
    logic                  unmapped;

    logic                  accept;
    logic                  resp_done;
    logic                  msip_we;
    logic                  mtime_we;
    logic                  mtimecmp_we;
    logic [DATA_WIDTH-1:0] rdata_c;

    logic                  msip;
    logic [DATA_WIDTH-1:0] mtime;
    logic [DATA_WIDTH-1:0] mtimecmp;
    logic                  timer_int;

    // Decode ignores the byte offset inside each 64-bit register.
    always_comb begin
        sel_msip  = ((i_req_addr >> 3) == (MSIP_A  >> 3));
        sel_cmp   = ((i_req_addr >> 3) == (CMP_A   >> 3));
        sel_mtime = ((i_req_addr >> 3) == (MTIME_A >> 3));
        unmapped  = !(sel_msip || sel_cmp || sel_mtime);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req_valid)  state_next = RESP;
            RESP:    if (i_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        resp_done   = 1'b0;
        msip_we     = 1'b0;
        mtime_we    = 1'b0;
        mtimecmp_we = 1'b0;
        case (state)
            IDLE:    accept    = i_req_valid;
            RESP:    resp_done = i_resp_ready;
            default: ;
        endcase
        if (accept && i_req_write) begin
            msip_we     = sel_msip;
            mtime_we    = sel_mtime;
            mtimecmp_we = sel_cmp;
        end
    end

    // Read value is sampled before this edge's write lands.
    always_comb begin
        rdata_c = '0;
        if (!i_req_write) begin
            if (sel_msip) begin
                rdata_c = DATA_WIDTH'(msip);
            end else if (sel_cmp) begin
                rdata_c = mtimecmp;
            end else if (sel_mtime) begin
                rdata_c = mtime;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            o_req_ready  <= 1'b1;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
        end else begin
            o_req_ready  <= (state_next == IDLE);
            o_resp_valid <= (state_next == RESP);
            if (accept) begin
                o_resp_rdata <= rdata_c;
                o_resp_err   <= unmapped;
            end else if (resp_done) begin
                o_resp_rdata <= '0;
                o_resp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            msip <= 1'b0;
        end else if (msip_we && i_req_wstrb[0]) begin
            msip <= i_req_wdata[0];
        end
    end

    assign o_software_int_call = msip;
    assign o_timer_int_call    = timer_int;

    ysyx_201979054_clint_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .TICK_DIV   (TICK_DIV)
    ) u_timer (
        .clk         (clk),
        .arst        (arst),
        .mtime_we    (mtime_we),
        .mtimecmp_we (mtimecmp_we),
        .wdata       (i_req_wdata),
        .wstrb       (i_req_wstrb),
        .mtime       (mtime),
        .mtimecmp    (mtimecmp),
        .timer_int   (timer_int)
    );

endmodule
